// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 16x-oversampled UART receive sequencer (start/data/stop) with LSB-first byte assembly
module uart_rx_ctrl #(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       RX,
  input  logic       TICK,
  output logic [7:0] DOUT,
  output logic       RX_DONE,
  output logic       FRAME_ERR
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [4:0] s;
  logic [2:0] n;
  logic [7:0] b;
  logic rx_m, rx_s;
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      s <= 5'd0;
      n <= 3'd0;
      b <= 8'd0;
      DOUT <= 8'd0;
      RX_DONE <= 1'b0;
      FRAME_ERR <= 1'b0;
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      RX_DONE <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          s <= 5'd0;
        end
        START: if (TICK) begin
          if (s == 5'd7) begin
            if (!rx_s) begin
              state <= DATA;
              s <= 5'd0;
              n <= 3'd0;
            end else state <= IDLE;
          end else s <= s + 5'd1;
        end
        DATA: if (TICK) begin
          if (s == 5'd15) begin
            s <= 5'd0;
            b <= {rx_s, b[7:1]};
            if (n == 3'(DBIT - 1)) state <= STOP;
            else n <= n + 3'd1;
          end else s <= s + 5'd1;
        end
        STOP: if (TICK) begin
          if (s == 5'(SB_TICK - 1)) begin
            DOUT <= b >> (8 - DBIT);
            FRAME_ERR <= ~rx_s;
            RX_DONE <= 1'b1;
            state <= IDLE;
          end else s <= s + 5'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
